uart_rcv: RTL and testbench

Serial receiver for the 8N1 UART link driven by the team's transmitter. It synchronizes the asynchronous `RX` line, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit. It then checks the stop bit and presents the byte with a sticky `rdy` flag until the consumer clears it. It sits between the board RX pin and the command/packet logic.

---
 rtl/uart_rcv.sv | 132 +++++++++++++
 tb/tb_uart_rcv.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
// uart_rcv: 8N1 serial receiver; synchronizes RX, validates the start bit, samples 8 data bits LSB-first at mid-bit.
// Latency: rdy/rx_data/frm_err update 2 + HALF + 9*BAUD_CYCLES edges after RX is first sampled low.
// Backpressure: none; rdy is sticky until clr_rdy, and a frame completing while rdy is still set raises ovr_err.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   RX       - asynchronous serial input, idles high
//   clr_rdy  - consumer acknowledge; clears rdy and ovr_err
//   rx_data  - last received byte, held until the next frame completes
//   rdy      - sticky new-byte flag
//   frm_err  - stop bit of the last completed frame was 0 (valid with rdy)
//   ovr_err  - sticky: a frame completed while rdy was still set
module uart_rcv #(
  parameter int BAUD_CYCLES = 109
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int HALF = BAUD_CYCLES / 2;
  localparam int CW   = $clog2(BAUD_CYCLES);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rx_m;
  logic            rx_s;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            start_smp;
  logic            data_smp;
  logic            stop_smp;
  logic            any_smp;

  always_comb begin
    state_nxt = state;
    start_smp = 1'b0;
    data_smp  = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (baud_cnt == HALF_M1) begin
          start_smp = 1'b1;
          // A high line at mid-start means the low level was a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_M1) begin
          data_smp = 1'b1;
          if (bit_cnt == 4'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets a start bit that directly follows be caught.
        if (baud_cnt == BAUD_M1) begin
          stop_smp  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign any_smp = start_smp | data_smp | stop_smp;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      rx_m  <= RX;
      rx_s  <= rx_m;
      state <= state_nxt;

      // Bit timing restarts on every state change and every sample.
      if (state == IDLE || state_nxt != state || any_smp)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (start_smp && !rx_s)
        bit_cnt <= '0;
      else if (data_smp)
        bit_cnt <= bit_cnt + 4'd1;

      // Shift right so the first (LSB) bit ends up in bit 0 after 8 shifts.
      if (data_smp)
        shreg <= {rx_s, shreg[7:1]};

      if (stop_smp) begin
        rx_data <= shreg;
        frm_err <= ~rx_s;
      end

      // Completion wins over a coincident clear.
      if (stop_smp)
        rdy <= 1'b1;
      else if (clr_rdy)
        rdy <= 1'b0;

      // A coincident clear acknowledges the old byte, so no overrun is flagged.
      if (clr_rdy)
        ovr_err <= 1'b0;
      else if (stop_smp && rdy)
        ovr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
module tb_uart_rcv;

  localparam int B = 109;
  localparam int H = B / 2;

  logic       clk;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int rise_q[$];
  logic rdy_q = 1'b0;

  // Reference state: what the outputs should hold, per the frame-level rules.
  logic [7:0] exp_data;
  logic       exp_rdy;
  logic       exp_frm;
  logic       exp_ovr;

  uart_rcv #(.BAUD_CYCLES(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge number of every rising edge of rdy.
  always @(negedge clk) begin
    if (rdy === 1'b1 && rdy_q !== 1'b1) rise_q.push_back(cyc);
    rdy_q = rdy;
  end

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rdy = 1'b0;
    exp_rdy = 1'b0;
    exp_ovr = 1'b0;
    checks++;
    if (rdy !== 1'b0 || ovr_err !== 1'b0 || frm_err !== exp_frm || rx_data !== exp_data) begin
      errors++;
      $display("FAIL clr: rdy=%b ovr=%b frm=%b data=%h, want rdy=0 ovr=0 frm=%b data=%h",
               rdy, ovr_err, frm_err, rx_data, exp_frm, exp_data);
    end
  endtask

  // Drives one full frame (start, 8 data LSB-first, stop) and checks the outputs
  // one edge before and right after the expected completion edge.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic clr_on_done, input logic clr_after);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    last_start = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      RX = bits[i];
      repeat (B) begin @(posedge clk); #1; end
    end
    RX = stop;
    for (int j = 1; j <= B; j++) begin
      @(posedge clk); #1;
      if (j == H + 2) begin
        checks++;
        if (rdy !== exp_rdy || rx_data !== exp_data || ovr_err !== exp_ovr) begin
          errors++;
          $display("FAIL pre_done %h: rdy=%b data=%h ovr=%b, want rdy=%b data=%h ovr=%b",
                   d, rdy, rx_data, ovr_err, exp_rdy, exp_data, exp_ovr);
        end
        if (clr_on_done) clr_rdy = 1'b1;
      end
      if (j == H + 3) begin
        clr_rdy = 1'b0;
        exp_ovr = clr_on_done ? 1'b0 : (exp_ovr | exp_rdy);
        exp_rdy  = 1'b1;
        exp_data = d;
        exp_frm  = ~stop;
        checks++;
        if (rdy !== exp_rdy || rx_data !== exp_data || frm_err !== exp_frm || ovr_err !== exp_ovr) begin
          errors++;
          $display("FAIL done %h: rdy=%b data=%h frm=%b ovr=%b, want rdy=%b data=%h frm=%b ovr=%b",
                   d, rdy, rx_data, frm_err, ovr_err, exp_rdy, exp_data, exp_frm, exp_ovr);
        end
        if (clr_after) clr_rdy = 1'b1;
      end
      if (j == H + 4 && clr_after) begin
        clr_rdy = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
        checks++;
        if (rdy !== 1'b0 || ovr_err !== 1'b0) begin
          errors++;
          $display("FAIL clr_after %h: rdy=%b ovr=%b, want 0 0", d, rdy, ovr_err);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; RX = 1'b1; clr_rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (rdy !== 1'b0 || rx_data !== 8'h00 || frm_err !== 1'b0 || ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b data=%h frm=%b ovr=%b, want all 0", rdy, rx_data, frm_err, ovr_err);
    end
    rst = 1'b0;
    exp_data = 8'h00; exp_rdy = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
    idle(5);
  endtask

  task automatic test_single();
    rise_q.delete();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    checks++;
    if (rise_q.size() != 1 || rise_q[0] != last_start + H + 9 * B + 2) begin
      errors++;
      $display("FAIL latency: rises=%0d first_edge=%0d, want 1 rise at edge %0d",
               rise_q.size(), (rise_q.size() > 0) ? rise_q[0] - last_start : -1, H + 9 * B + 2);
    end
    idle(10);
  endtask

  task automatic test_back_to_back();
    rise_q.delete();
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    checks++;
    if (rise_q.size() != 2 || rise_q[1] - rise_q[0] != 10 * B) begin
      errors++;
      $display("FAIL back_to_back: rises=%0d spacing=%0d, want 2 rises %0d apart",
               rise_q.size(), (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : -1, 10 * B);
    end
    idle(10);
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ovr_err !== 1'b1 || rx_data !== 8'hC3) begin
      errors++;
      $display("FAIL overrun: ovr=%b data=%h, want ovr=1 data=c3", ovr_err, rx_data);
    end
    pulse_clr();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    checks++;
    if (rdy !== 1'b1 || ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_clr: rdy=%b ovr=%b, want rdy=1 ovr=0", rdy, ovr_err);
    end
    pulse_clr();
    idle(10);
  endtask

  task automatic test_frame_err_glitch();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle(2 * B);
    pulse_clr();  // frm_err must survive the clear
    rise_q.delete();
    RX = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    idle(200);
    checks++;
    if (rise_q.size() != 0 || rdy !== 1'b0 || rx_data !== exp_data) begin
      errors++;
      $display("FAIL glitch: rises=%0d rdy=%b data=%h, want no rise rdy=0 data=%h",
               rise_q.size(), rdy, rx_data, exp_data);
    end
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    idle(10);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       st;
    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom);
      st = ($urandom % 4) != 0;
      send_frame(d, st, 1'($urandom % 2), 1'($urandom % 2));
      // After a low stop bit the line needs a full bit time high to resettle.
      idle(st ? int'($urandom % 3) : B);
    end
    pulse_clr();
    idle(10);
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    send_frame(8'h6E, 1'b0, 1'b0, 1'b0);  // leave rdy and frm_err set
    idle(B);
    bits = {1'b1, 8'h96, 1'b0};
    rise_q.delete();
    for (int i = 0; i < 5; i++) begin
      RX = bits[i];
      repeat (B) begin @(posedge clk); #1; end
    end
    RX = bits[5];
    repeat (H) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (rdy !== 1'b0 || rx_data !== 8'h00 || frm_err !== 1'b0 || ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b data=%h frm=%b ovr=%b, want all 0", rdy, rx_data, frm_err, ovr_err);
    end
    rst = 1'b0;
    exp_data = 8'h00; exp_rdy = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
    idle(3 * B);
    checks++;
    if (rise_q.size() != 0 || rdy !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL partial_frame: rises=%0d rdy=%b data=%h, want none 0 00", rise_q.size(), rdy, rx_data);
    end
    send_frame(8'h18, 1'b1, 1'b0, 1'b0);
    idle(10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err_glitch();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
